// File: rtl/burst_mem_pkg.sv
// burst_mem_pkg
// Shared types and constants for the burst memory responder.
//   state_t        : responder FSM states
//   BEATS          : beats per burst (one 256-bit line = 4 x 64-bit words)
//   BEAT_W         : width of one beat / stored word
//   LINE_OFFSET_W  : byte-offset bits inside one 32-byte line
//   WORD_SEL_W     : bits selecting a word inside a line
package burst_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAT,
    RBURST,
    WBURST,
    DONE
  } state_t;

  localparam int BEATS         = 4;
  localparam int BEAT_W        = 64;
  localparam int LINE_OFFSET_W = 5;
  localparam int WORD_SEL_W    = 2;

endpackage

// File: rtl/burst_mem_array.sv
// burst_mem_array
// 1R1W word array with a registered (one-cycle) read port. Contents are not
// reset; never-written words read as X in simulation.
// Ports:
//   clk    : clock
//   raddr  : read word address, sampled every rising edge
//   rdata  : read data, valid the cycle after raddr is presented
//   we     : write enable
//   waddr  : write word address
//   wdata  : write data
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BEAT_W-1:0] rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BEAT_W-1:0] wdata
);

  localparam int WORDS = 2 ** ADDR_W;

  logic [BEAT_W-1:0] mem [WORDS];
  logic [BEAT_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder
// Four-beat burst memory slave. A request accepted at edge T produces beats
// in cycles T+LATENCY .. T+LATENCY+3, followed by one DONE cycle.
// Build option: define BURST_MEM_CRITICAL_WORD_FIRST_EN to start each burst
// at word address_i[4:3] and wrap modulo 4; otherwise beats run 0,1,2,3.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   read_i    : burst read request, held until the 4th beat
//   write_i   : burst write request, held until the 4th beat
//   address_i : byte address of a 32-byte line
//   burst_i   : write beat data
//   burst_o   : read beat data (0 when resp_o is low)
//   resp_o    : beat-valid strobe
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [31:0]       address_i,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic              resp_o
);

  localparam int LINE_W = $clog2(DEPTH_LINES);
  localparam int ADDR_W = LINE_W + WORD_SEL_W;

  state_t                  state_reg, state_next;
  logic [3:0]              lat_cnt_reg, lat_cnt_next;
  logic [WORD_SEL_W-1:0]   beat_reg, beat_next;
  logic [LINE_W-1:0]       line_reg, line_next;
  logic [WORD_SEL_W-1:0]   start_reg, start_next;
  logic                    is_read_reg, is_read_next;

  logic                    req_active;
  logic                    beat_on;
  logic [WORD_SEL_W-1:0]   rd_word;
  logic [WORD_SEL_W-1:0]   wr_word;
  logic [WORD_SEL_W-1:0]   start_word;
  logic [ADDR_W-1:0]       raddr;
  logic [ADDR_W-1:0]       waddr;
  logic                    we;
  logic [BEAT_W-1:0]       rdata;

`ifdef BURST_MEM_CRITICAL_WORD_FIRST_EN
  assign start_word = address_i[LINE_OFFSET_W-1 -: WORD_SEL_W];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address_i[31:LINE_OFFSET_W+LINE_W], address_i[2:0]};
`else
  assign start_word = '0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address_i[31:LINE_OFFSET_W+LINE_W], address_i[LINE_OFFSET_W-1:0]};
`endif

  // The request that was accepted must stay high; its drop aborts the transfer.
  assign req_active = is_read_reg ? read_i : write_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= '0;
      beat_reg    <= '0;
      line_reg    <= '0;
      start_reg   <= '0;
      is_read_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
      beat_reg    <= beat_next;
      line_reg    <= line_next;
      start_reg   <= start_next;
      is_read_reg <= is_read_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = lat_cnt_reg;
    beat_next    = beat_reg;
    line_next    = line_reg;
    start_next   = start_reg;
    is_read_next = is_read_reg;
    case (state_reg)
      IDLE: begin
        lat_cnt_next = '0;
        beat_next    = '0;
        if (read_i || write_i) begin
          state_next   = LAT;
          is_read_next = read_i;
          line_next    = address_i[LINE_OFFSET_W +: LINE_W];
          start_next   = start_word;
        end
      end
      LAT: begin
        if (!req_active) begin
          state_next   = IDLE;
          lat_cnt_next = '0;
        end else if (lat_cnt_reg == 4'(LATENCY - 1)) begin
          state_next   = is_read_reg ? RBURST : WBURST;
          lat_cnt_next = '0;
        end else begin
          lat_cnt_next = lat_cnt_reg + 4'd1;
        end
      end
      RBURST, WBURST: begin
        if (!req_active) begin
          state_next = IDLE;
          beat_next  = '0;
        end else if (beat_reg == WORD_SEL_W'(BEATS - 1)) begin
          state_next = DONE;
          beat_next  = '0;
        end else begin
          beat_next = beat_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read port runs one word ahead of the beat: during the last LAT cycle it
  // fetches the first word, during beat k it fetches the word for beat k+1.
  assign rd_word = start_reg + ((state_reg == RBURST) ? beat_reg + 1'b1 : '0);
  assign wr_word = start_reg + beat_reg;
  assign raddr   = {line_reg, rd_word};
  assign waddr   = {line_reg, wr_word};

  assign beat_on = ((state_reg == RBURST) || (state_reg == WBURST)) && req_active;
  assign we      = (state_reg == WBURST) && write_i && !rst;

  assign resp_o  = beat_on;
  assign burst_o = (beat_on && (state_reg == RBURST)) ? rdata : '0;

  burst_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (burst_i)
  );

endmodule

// File: tb/tb_burst_mem_responder.sv
module tb_burst_mem_responder;

  localparam int L  = 4;
  localparam int D  = 256;
  localparam int LW = 8;
  localparam int NONE = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_i = 1'b0;
  logic        write_i = 1'b0;
  logic [31:0] address_i = '0;
  logic [63:0] burst_i = '0;
  logic [63:0] burst_o;
  logic        resp_o;

  always #5 clk = ~clk;

  burst_mem_responder #(
    .DEPTH_LINES(D),
    .LATENCY    (L)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .read_i   (read_i),
    .write_i  (write_i),
    .address_i(address_i),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .resp_o   (resp_o)
  );

  // Reference memory: word-granular, with a flag for words that hold known data.
  logic [63:0] model [D*4];
  bit          known [D*4];
  logic [63:0] wbeat [4];

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One transfer. drop: cycle (0 = first cycle after acceptance) from which the
  // request is released; rst_at: cycle in which reset is pulsed; keep: leave the
  // request asserted through DONE so the next call is accepted straight away.
  task automatic xfer(input bit rd, input bit wr, input logic [31:0] addr,
                      input int drop, input int rst_at, input bit keep);
    int  start;
    int  line;
    int  last;
    int  k;
    int  widx;
    bit  req;
    bit  exp_resp;
    bit  is_wr_op;
    logic [63:0] exp_data;
    logic [31:0] a;
    a = addr;
`ifdef BURST_MEM_CRITICAL_WORD_FIRST_EN
    start = int'(a[4:3]);
`else
    start = 0;
`endif
    line     = int'(a[5 +: LW]);
    is_wr_op = !rd && wr;
    if (drop <= L + 3 || rst_at <= L + 3)
      last = ((drop < rst_at) ? drop : rst_at) + 1;
    else
      last = keep ? L + 4 : L + 5;
    $display("xfer rd=%0b wr=%0b addr=%h drop=%0d rst_at=%0d keep=%0b",
             rd, wr, addr, drop, rst_at, keep);
    @(negedge clk);
    read_i    = rd;
    write_i   = wr;
    address_i = addr;
    @(posedge clk);
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      req       = (n < drop) && (n <= rst_at) && (keep || n < L + 4);
      read_i    = rd & req;
      write_i   = wr & req;
      address_i = $urandom;
      rst       = (n == rst_at);
      k         = n - L;
      widx      = line * 4 + ((start + k) & 3);
      burst_i   = (k >= 0 && k < 4) ? wbeat[k & 3] : rnd64();
      #1;
      exp_resp = (k >= 0) && (k < 4) && req;
      if (n != rst_at) begin
        chk("resp_o", {63'd0, resp_o}, {63'd0, exp_resp});
        if (exp_resp && rd) begin
          if (known[widx]) begin
            exp_data = model[widx];
            chk("burst_o_read", burst_o, exp_data);
          end
        end else begin
          chk("burst_o_zero", burst_o, 64'd0);
        end
        if (exp_resp && is_wr_op) begin
          model[widx] = wbeat[k & 3];
          known[widx] = 1'b1;
        end
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4; i++) wbeat[i] = rnd64();
  endtask

  initial begin
    int op;
    int drop;
    bit keep;
    logic [31:0] addr;

    for (int i = 0; i < D * 4; i++) known[i] = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_resp_o", {63'd0, resp_o}, 64'd0);
    chk("reset_burst_o", burst_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed write/read of line 0x40
    wbeat[0] = 64'h1111_1111_1111_1111;
    wbeat[1] = 64'h2222_2222_2222_2222;
    wbeat[2] = 64'h3333_3333_3333_3333;
    wbeat[3] = 64'h4444_4444_4444_4444;
    xfer(1'b0, 1'b1, 32'h40, NONE, NONE, 1'b0);
    fill_random();
    xfer(1'b1, 1'b0, 32'h40, NONE, NONE, 1'b0);

    // Preload further lines
    fill_random(); xfer(1'b0, 1'b1, 32'h0,   NONE, NONE, 1'b0);
    fill_random(); xfer(1'b0, 1'b1, 32'h80,  NONE, NONE, 1'b0);
    fill_random(); xfer(1'b0, 1'b1, 32'h100, NONE, NONE, 1'b0);

    // Read wins over write; memory must stay unchanged
    fill_random(); xfer(1'b1, 1'b1, 32'h80, NONE, NONE, 1'b0);
    fill_random(); xfer(1'b1, 1'b0, 32'h80, NONE, NONE, 1'b0);

    // Aliasing of upper address bits
    xfer(1'b1, 1'b0, 32'h0,    NONE, NONE, 1'b0);
    xfer(1'b1, 1'b0, 32'h2000, NONE, NONE, 1'b0);

    // Write aborted after beat 1, then read back
    fill_random(); xfer(1'b0, 1'b1, 32'h100, L + 2, NONE, 1'b0);
    xfer(1'b1, 1'b0, 32'h100, NONE, NONE, 1'b0);

    // Reset during beat 2 of a read, then a normal read
    xfer(1'b1, 1'b0, 32'h40, NONE, L + 2, 1'b0);
    xfer(1'b1, 1'b0, 32'h40, NONE, NONE, 1'b0);

    // Back-to-back reads with requests held through DONE
    xfer(1'b1, 1'b0, 32'h58, NONE, NONE, 1'b1);
    xfer(1'b1, 1'b0, 32'h58, NONE, NONE, 1'b1);
    xfer(1'b1, 1'b0, 32'h80, NONE, NONE, 1'b0);

    // Drops during the latency phase
    xfer(1'b1, 1'b0, 32'h40, 2, NONE, 1'b0);
    fill_random(); xfer(1'b0, 1'b1, 32'h40, 1, NONE, 1'b0);
    xfer(1'b1, 1'b0, 32'h40, NONE, NONE, 1'b0);

    // Randomized traffic over 16 lines with random upper/offset bits
    for (int t = 0; t < 40; t++) begin
      op   = $urandom_range(0, 2);
      addr = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 15)) << 5) |
             32'($urandom_range(0, 31));
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, L + 3) : NONE;
      keep = (drop == NONE) && ($urandom_range(0, 2) == 0);
      fill_random();
      xfer(op != 1, op != 0, addr, drop, NONE, keep);
    end
    xfer(1'b1, 1'b0, 32'h58, NONE, NONE, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LINES, default 256: number of 256-bit lines stored (power of 2).
REQ-002 SHALL have parameter LATENCY, default 4: cycles from request acceptance to first beat (1..15).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port read_i  input  1  burst read request, held high by the initiator until the 4th beat.
REQ-006 SHALL have port write_i  input  1  burst write request, held high by the initiator until the 4th beat.
REQ-007 SHALL have port address_i  input  32  byte address of a 32-byte line.
REQ-008 SHALL have port burst_i  input  64  write beat data.
REQ-009 SHALL have port burst_o  output  64  read beat data.
REQ-010 SHALL have port resp_o  output  1  beat-valid strobe, one per beat.

Function
REQ-011 SHALL store DEPTH_LINES*4 64-bit words; line index = address_i[5+log2(DEPTH_LINES)-1:5], with upper bits ignored (aliasing wrap) and address_i[4:0] ignored unless REQ-024 applies.
REQ-012 SHALL implement FSM IDLE -> LAT -> RBURST|WBURST -> DONE -> IDLE.
REQ-013 In IDLE, SHALL accept a request when read_i or write_i is high, capturing address and direction; read wins when both are high.
REQ-014 SHALL ignore address_i changes after acceptance.
REQ-015 If accepted at edge T, SHALL drive resp_o high in cycles T+LATENCY .. T+LATENCY+3 (4 consecutive beats, no gaps).
REQ-016 Read: on beat k (0..3), burst_o SHALL equal word k of the line (beat 0 = line bits [63:0]); burst_o SHALL be 0 whenever resp_o is 0.
REQ-017 Write: SHALL write burst_i into word k at the edge ending beat k; each beat commits independently.
REQ-018 After beat 3, SHALL spend exactly one DONE cycle with resp_o=0 and requests ignored, then return to IDLE; a request held in IDLE is accepted there.
REQ-019 If the active request input drops in LAT or mid-burst, SHALL return to IDLE at the next edge with resp_o=0; write beats already committed stay written.
REQ-020 A read of a word written by an earlier completed burst SHALL return the new data; there is no same-cycle read/write conflict because transfers are serialized.

Reset
REQ-021 While rst is high, SHALL force the FSM to IDLE, resp_o=0, burst_o=0 and the latency/beat counters to 0, aborting any transfer in the next cycle.
REQ-022 SHALL NOT reset array contents; words never written read as X in simulation.

Configuration
REQ-023 Macro BURST_MEM_CRITICAL_WORD_FIRST_EN SHALL select beat ordering.
REQ-024 With the macro defined, SHALL start reads and writes at word w = captured address_i[4:3] and order beats w, w+1, ... modulo 4.
REQ-025 Without the macro, SHALL always order beats 0,1,2,3 and ignore address_i[4:3].

Structure
REQ-026 Package burst_mem_pkg SHALL hold: state enum (IDLE, LAT, RBURST, WBURST, DONE), BEATS=4, BEAT_W=64, LINE_OFFSET_W=5.
REQ-027 Sub-module burst_mem_array SHALL implement the 1R1W 64-bit word array with synchronous read; the responder SHALL issue read addresses early enough to meet REQ-015.

Verification
REQ-028 Reset, then write 0x40 with beats 0x11..,0x22..,0x33..,0x44.. (LATENCY=4) -> resp_o high in cycles 4-7 after acceptance, then DONE; read 0x40 -> same four words in order.
REQ-029 read_i and write_i both high at 0x80 -> read performed and memory unchanged.
REQ-030 Read at 0x0 versus 0x2000 with DEPTH_LINES=256 -> same line (alias), identical data.
REQ-031 Write at 0x100 with write_i dropped after beat 1 -> words 0-1 updated, words 2-3 unchanged, resp_o low the next cycle, FSM in IDLE.
REQ-032 rst asserted during beat 2 of a read -> resp_o=0 and burst_o=0 the next cycle; a subsequent read completes normally.
REQ-033 With BURST_MEM_CRITICAL_WORD_FIRST_EN defined, read 0x58 -> beats in order word 3,0,1,2; back-to-back reads -> exactly one idle cycle between bursts.
